reg_xfer_sequencer: RTL and testbench
=====================================

// Module: reg_xfer_sequencer
// PURPOSE
// Control-side initiator for the register select/encode logic: latches an instruction word on start and
// steps through T-states, driving Gra/Grb/Grc/Rin/Rout/BAout plus Y/Z/HI/LO/C-sign-ext strobes and the ALU op.
// Executes the register-ALU, immediate-ALU, mul/div and unary instruction classes.
// Sits between fetch control and the datapath; the select/encode logic turns its strobes into R0-R15 enables.
// PARAMETERS
// MULDIV_EN  1  1: mul/div sequenced; 0: opcodes 01111/10000 are treated as illegal
// OP_W       5  opcode width (IR[31:27]); alu_op width
// PORTS
// clk       in   1     rising-edge clock
// clear     in   1     synchronous active-high reset
// start     in   1     begin execution of ir; sampled only in IDLE
// ir        in   32    instruction word; opcode IR[31:27], Ra [26:23], Rb [22:19], Rc [18:15]
// busy      out  1     high in every non-IDLE state
// done      out  1     one-cycle pulse in the final T-state
// illegal   out  1     one-cycle pulse after start with an unsupported opcode
// gra/grb/grc out 1    register-field selects (at most one high per cycle)
// rin       out  1     write the selected register from the bus
// rout      out  1     drive the selected register onto the bus
// baout     out  1     always equal to rout (the select logic gates Rout with BAout)
// yin       out  1     load Y from the bus
// cout      out  1     drive sign-extended C (IR[18:0]) onto the bus
// zin       out  1     load Z from the ALU
// zlowout   out  1     drive Z[31:0] onto the bus
// zhighout  out  1     drive Z[63:32] onto the bus
// loin/hiin out 1      load LO / HI from the bus
// alu_op    out  OP_W  latched opcode during the zin state; 0 otherwise
// BEHAVIOUR
// - The opcode is latched on the edge that accepts start. Strobes are Moore outputs: combinational from
//   the state register and the latched opcode only.
// - Classes by opcode:
//   * RR  = 00011..01011 (add, sub, and, or, shr, shra, shl, ror, rol)
//   * IMM = 01100..01110 (addi, andi, ori)
//   * MD  = 01111 mul, 10000 div
//   * UN  = 10001 neg, 10010 not
//   * any other opcode is illegal.
// - States: IDLE, T3, T4, T5, T6, ERR.
// - IDLE: all outputs 0. On start=1, go to ERR if illegal, else to T3.
// - T3 by class:
//   * RR/IMM/MD: grb, rout, baout, yin.
//   * UN: grb, rout, baout, zin, alu_op.
// - T4 by class:
//   * RR/MD: grc, rout, baout, zin, alu_op.
//   * IMM: cout, zin, alu_op.
//   * UN: zlowout, gra, rin, done; then go to IDLE.
// - T5 by class:
//   * RR/IMM: zlowout, gra, rin, done; then go to IDLE.
//   * MD: zlowout, loin.
// - T6 (MD only): zhighout, hiin, done; then go to IDLE.
// - ERR: illegal=1 for one cycle, no strobes; then go to IDLE.
// - Latency from start to done: RR/IMM 3 cycles, UN 2, MD 4. A new start may be accepted on the cycle
//   after done (IDLE), so back-to-back instructions take one idle cycle between them.
// - start while busy is ignored: no queuing, and the latched opcode is unchanged.
// - clear in any state: the next edge returns to IDLE with all outputs 0 and the latched opcode at 0.
//   If clear and start are both high, clear wins.
// - Invariants checked by the bench:
//   * never more than one of gra/grb/grc high;
//   * rout and cout never both high;
//   * never more than one of {rout, cout, zlowout, zhighout} high.
// TESTING
// - Reset: clear=1 for 2 cycles with start=1 -> all outputs 0, busy=0.
// - Add: ir={00011,4'd3,4'd1,4'd2,15'd0}, start 1 cycle ->
//   * T3: grb rout baout yin
//   * T4: grc rout baout zin, alu_op=00011
//   * T5: zlowout gra rin done
//   * then IDLE.
// - Addi: opcode 01100 -> T4 has cout=1, rout=0, grc=0; done is in the 3rd cycle after start.
// - Mul: opcode 01111 with MULDIV_EN=1 -> T5: zlowout loin; T6: zhighout hiin done.
//   With MULDIV_EN=0 the same opcode gives illegal=1 for one cycle and no strobes.
// - Not: opcode 10010 -> 2-cycle sequence, done in T4; opcode 11111 -> illegal pulse, busy for 1 cycle.
// - Hazards: start re-asserted in T4 is ignored (alu_op is unchanged); clear asserted in T4 -> IDLE
//   on the next cycle, and done never pulses.

Source files
------------

// File: rtl/reg_xfer_sequencer_if.sv
// Handshake and datapath-strobe bundle between fetch control, the T-state sequencer and the
// register select/encode logic.
interface reg_xfer_sequencer_if #(
  parameter int OP_W = 5
);
  logic            start;
  logic [31:0]     ir;
  logic            busy;
  logic            done;
  logic            illegal;
  logic            gra;
  logic            grb;
  logic            grc;
  logic            rin;
  logic            rout;
  logic            baout;
  logic            yin;
  logic            cout;
  logic            zin;
  logic            zlowout;
  logic            zhighout;
  logic            loin;
  logic            hiin;
  logic [OP_W-1:0] alu_op;

  // master: the sequencer, which drives the strobes
  modport master (
    input  start, ir,
    output busy, done, illegal, gra, grb, grc, rin, rout, baout, yin, cout,
           zin, zlowout, zhighout, loin, hiin, alu_op
  );

  modport slave (
    output start, ir,
    input  busy, done, illegal, gra, grb, grc, rin, rout, baout, yin, cout,
           zin, zlowout, zhighout, loin, hiin, alu_op
  );
endinterface

// File: rtl/reg_xfer_sequencer.sv
// T-state sequencer for register-ALU, immediate-ALU, mul/div and unary instructions.
// Strobes are Moore outputs decoded from the state register and the latched opcode.
module reg_xfer_sequencer #(
  parameter int MULDIV_EN = 1,
  parameter int OP_W      = 5
) (
  input  logic                 clk,
  input  logic                 clear,
  reg_xfer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_ERR
  } state_t;

  typedef enum logic [2:0] {
    CL_RR,
    CL_IMM,
    CL_MD,
    CL_UN,
    CL_ILL
  } op_class_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(5'b00011);
  localparam logic [OP_W-1:0] OP_ROL  = OP_W'(5'b01011);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5'b01100);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(5'b01110);
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(5'b01111);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(5'b10000);
  localparam logic [OP_W-1:0] OP_NEG  = OP_W'(5'b10001);
  localparam logic [OP_W-1:0] OP_NOT  = OP_W'(5'b10010);

  function automatic op_class_t classify(input logic [OP_W-1:0] op);
    op_class_t cl;
    cl = CL_ILL;
    if (op >= OP_ADD && op <= OP_ROL)
      cl = CL_RR;
    else if (op >= OP_ADDI && op <= OP_ORI)
      cl = CL_IMM;
    else if ((op == OP_MUL || op == OP_DIV) && (MULDIV_EN != 0))
      cl = CL_MD;
    else if (op == OP_NEG || op == OP_NOT)
      cl = CL_UN;
    return cl;
  endfunction

  state_t          state_reg;
  state_t          state_next;
  logic [OP_W-1:0] opcode_reg;
  logic [OP_W-1:0] ir_op;
  op_class_t       start_class;
  op_class_t       cur_class;

  assign ir_op       = bus.ir[31 -: OP_W];
  assign start_class = classify(ir_op);
  assign cur_class   = classify(opcode_reg);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg  <= ST_IDLE;
      opcode_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Only IDLE accepts start, so a start while busy leaves the opcode alone.
      if (state_reg == ST_IDLE && bus.start)
        opcode_reg <= ir_op;
    end
  end

  logic gra, grb, grc, rin, rout, yin, cout, zin;
  logic zlowout, zhighout, loin, hiin, done, illegal;

  always_comb begin
    state_next = state_reg;
    gra        = 1'b0;
    grb        = 1'b0;
    grc        = 1'b0;
    rin        = 1'b0;
    rout       = 1'b0;
    yin        = 1'b0;
    cout       = 1'b0;
    zin        = 1'b0;
    zlowout    = 1'b0;
    zhighout   = 1'b0;
    loin       = 1'b0;
    hiin       = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.start)
          state_next = (start_class == CL_ILL) ? ST_ERR : ST_T3;
      end
      ST_T3: begin
        grb  = 1'b1;
        rout = 1'b1;
        // Unary ops feed the ALU straight from Rb; everything else parks Rb in Y.
        if (cur_class == CL_UN)
          zin = 1'b1;
        else
          yin = 1'b1;
        state_next = ST_T4;
      end
      ST_T4: begin
        case (cur_class)
          CL_UN: begin
            zlowout    = 1'b1;
            gra        = 1'b1;
            rin        = 1'b1;
            done       = 1'b1;
            state_next = ST_IDLE;
          end
          CL_IMM: begin
            cout       = 1'b1;
            zin        = 1'b1;
            state_next = ST_T5;
          end
          default: begin
            grc        = 1'b1;
            rout       = 1'b1;
            zin        = 1'b1;
            state_next = ST_T5;
          end
        endcase
      end
      ST_T5: begin
        zlowout = 1'b1;
        if (cur_class == CL_MD) begin
          loin       = 1'b1;
          state_next = ST_T6;
        end else begin
          gra        = 1'b1;
          rin        = 1'b1;
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_T6: begin
        zhighout   = 1'b1;
        hiin       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        illegal    = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = done;
  assign bus.illegal  = illegal;
  assign bus.gra      = gra;
  assign bus.grb      = grb;
  assign bus.grc      = grc;
  assign bus.rin      = rin;
  assign bus.rout     = rout;
  assign bus.baout    = rout;
  assign bus.yin      = yin;
  assign bus.cout     = cout;
  assign bus.zin      = zin;
  assign bus.zlowout  = zlowout;
  assign bus.zhighout = zhighout;
  assign bus.loin     = loin;
  assign bus.hiin     = hiin;
  assign bus.alu_op   = zin ? opcode_reg : '0;

endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// Directed bench for reg_xfer_sequencer: one DUT with mul/div enabled, one without, same stimulus.
module tb_reg_xfer_sequencer;

  localparam logic [15:0] B_GRA   = 16'h8000;
  localparam logic [15:0] B_GRB   = 16'h4000;
  localparam logic [15:0] B_GRC   = 16'h2000;
  localparam logic [15:0] B_RIN   = 16'h1000;
  localparam logic [15:0] B_ROUT  = 16'h0800;
  localparam logic [15:0] B_BAOUT = 16'h0400;
  localparam logic [15:0] B_YIN   = 16'h0200;
  localparam logic [15:0] B_COUT  = 16'h0100;
  localparam logic [15:0] B_ZIN   = 16'h0080;
  localparam logic [15:0] B_ZLO   = 16'h0040;
  localparam logic [15:0] B_ZHI   = 16'h0020;
  localparam logic [15:0] B_LOIN  = 16'h0010;
  localparam logic [15:0] B_HIIN  = 16'h0008;
  localparam logic [15:0] B_DONE  = 16'h0004;
  localparam logic [15:0] B_ILL   = 16'h0002;
  localparam logic [15:0] B_BUSY  = 16'h0001;

  localparam logic [15:0] E_RR_T3  = B_GRB | B_ROUT | B_BAOUT | B_YIN | B_BUSY;
  localparam logic [15:0] E_UN_T3  = B_GRB | B_ROUT | B_BAOUT | B_ZIN | B_BUSY;
  localparam logic [15:0] E_RR_T4  = B_GRC | B_ROUT | B_BAOUT | B_ZIN | B_BUSY;
  localparam logic [15:0] E_IMM_T4 = B_COUT | B_ZIN | B_BUSY;
  localparam logic [15:0] E_WB     = B_ZLO | B_GRA | B_RIN | B_DONE | B_BUSY;
  localparam logic [15:0] E_MD_T5  = B_ZLO | B_LOIN | B_BUSY;
  localparam logic [15:0] E_MD_T6  = B_ZHI | B_HIIN | B_DONE | B_BUSY;
  localparam logic [15:0] E_ERR    = B_ILL | B_BUSY;

  localparam logic [31:0] IR_ADD  = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] IR_SUB  = {5'b00100, 4'd5, 4'd6, 4'd7, 15'd0};
  localparam logic [31:0] IR_ADDI = {5'b01100, 4'd2, 4'd4, 19'h0_0123};
  localparam logic [31:0] IR_ANDI = {5'b01101, 4'd1, 4'd9, 19'h7_ffff};
  localparam logic [31:0] IR_MUL  = {5'b01111, 4'd0, 4'd3, 4'd4, 15'd0};
  localparam logic [31:0] IR_NOT  = {5'b10010, 4'd8, 4'd9, 4'd0, 15'd0};
  localparam logic [31:0] IR_BAD  = {5'b11111, 27'd0};

  typedef logic [20:0] vec_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] ir;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  reg_xfer_sequencer_if #(.OP_W(5)) if0 ();
  reg_xfer_sequencer_if #(.OP_W(5)) if1 ();

  assign if0.start = start;
  assign if0.ir    = ir;
  assign if1.start = start;
  assign if1.ir    = ir;

  reg_xfer_sequencer #(.MULDIV_EN(1), .OP_W(5)) dut0 (.clk(clk), .clear(clear), .bus(if0));
  reg_xfer_sequencer #(.MULDIV_EN(0), .OP_W(5)) dut1 (.clk(clk), .clear(clear), .bus(if1));

  function automatic vec_t obs0();
    return {if0.gra, if0.grb, if0.grc, if0.rin, if0.rout, if0.baout, if0.yin, if0.cout,
            if0.zin, if0.zlowout, if0.zhighout, if0.loin, if0.hiin, if0.done, if0.illegal,
            if0.busy, if0.alu_op};
  endfunction

  function automatic vec_t obs1();
    return {if1.gra, if1.grb, if1.grc, if1.rin, if1.rout, if1.baout, if1.yin, if1.cout,
            if1.zin, if1.zlowout, if1.zhighout, if1.loin, if1.hiin, if1.done, if1.illegal,
            if1.busy, if1.alu_op};
  endfunction

  function automatic vec_t mk(input logic [15:0] s, input logic [4:0] op);
    return {s, op};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Structural invariants on both DUTs, every cycle.
  always @(negedge clk) begin
    n_checks++;
    if (!$onehot0({if0.gra, if0.grb, if0.grc}) || !$onehot0({if1.gra, if1.grb, if1.grc}))
      $display("FAIL inv_gr got %b/%b want onehot0", {if0.gra, if0.grb, if0.grc},
               {if1.gra, if1.grb, if1.grc});
    else
      n_pass++;
    n_checks++;
    if (!$onehot0({if0.rout, if0.cout, if0.zlowout, if0.zhighout}) ||
        !$onehot0({if1.rout, if1.cout, if1.zlowout, if1.zhighout}))
      $display("FAIL inv_bus got %b/%b want onehot0",
               {if0.rout, if0.cout, if0.zlowout, if0.zhighout},
               {if1.rout, if1.cout, if1.zlowout, if1.zhighout});
    else
      n_pass++;
    n_checks++;
    if (if0.baout !== if0.rout || if1.baout !== if1.rout)
      $display("FAIL inv_baout got %b%b want %b%b", if0.baout, if1.baout, if0.rout, if1.rout);
    else
      n_pass++;
  end

  task automatic test_reset();
    clear = 1'b1;
    start = 1'b1;
    ir    = IR_ADD;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (obs0() !== 21'd0 || obs1() !== 21'd0)
        $display("FAIL reset[%0d] got %h/%h want 000000", i, obs0(), obs1());
      else
        n_pass++;
    end
    clear = 1'b0;
    start = 1'b0;
    step();
    $display("test_reset: clear with start held, outputs idle");
  endtask

  task automatic test_add();
    vec_t e[4];
    e[0] = mk(E_RR_T3, 5'd0);
    e[1] = mk(E_RR_T4, 5'b00011);
    e[2] = mk(E_WB, 5'd0);
    e[3] = 21'd0;
    ir    = IR_ADD;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL add[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    $display("test_add: ir=%h sequenced", IR_ADD);
  endtask

  task automatic test_addi();
    vec_t e[4];
    e[0] = mk(E_RR_T3, 5'd0);
    e[1] = mk(E_IMM_T4, 5'b01100);
    e[2] = mk(E_WB, 5'd0);
    e[3] = 21'd0;
    ir    = IR_ADDI;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL addi[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    $display("test_addi: ir=%h sequenced", IR_ADDI);
  endtask

  task automatic test_mul();
    vec_t e0[5];
    vec_t e1[5];
    e0[0] = mk(E_RR_T3, 5'd0);
    e0[1] = mk(E_RR_T4, 5'b01111);
    e0[2] = mk(E_MD_T5, 5'd0);
    e0[3] = mk(E_MD_T6, 5'd0);
    e0[4] = 21'd0;
    e1[0] = mk(E_ERR, 5'd0);
    for (int i = 1; i < 5; i++) e1[i] = 21'd0;
    ir    = IR_MUL;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs0() !== e0[i])
        $display("FAIL mul_en[%0d] got %h want %h", i, obs0(), e0[i]);
      else
        n_pass++;
      n_checks++;
      if (obs1() !== e1[i])
        $display("FAIL mul_dis[%0d] got %h want %h", i, obs1(), e1[i]);
      else
        n_pass++;
    end
    $display("test_mul: ir=%h sequenced / illegal without muldiv", IR_MUL);
  endtask

  task automatic test_unary_and_illegal();
    vec_t e[3];
    e[0] = mk(E_UN_T3, 5'b10010);
    e[1] = mk(E_WB, 5'd0);
    e[2] = 21'd0;
    ir    = IR_NOT;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL not[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    $display("test_not: ir=%h sequenced", IR_NOT);
    e[0] = mk(E_ERR, 5'd0);
    e[1] = 21'd0;
    ir    = IR_BAD;
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      start = 1'b0;
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL bad[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    $display("test_illegal: ir=%h rejected", IR_BAD);
  endtask

  task automatic test_start_while_busy();
    vec_t e[5];
    e[0] = mk(E_RR_T3, 5'd0);
    e[1] = mk(E_RR_T4, 5'b00011);
    e[2] = mk(E_WB, 5'd0);
    e[3] = 21'd0;
    e[4] = 21'd0;
    ir    = IR_ADD;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      // start stays up with a different instruction through T3/T4, dropped in T5
      if (i == 0) ir = IR_SUB;
      if (i == 2) start = 1'b0;
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL busy_start[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    $display("test_start_while_busy: second start ignored");
  endtask

  task automatic test_clear_mid();
    vec_t e[4];
    e[0] = mk(E_RR_T3, 5'd0);
    e[1] = mk(E_RR_T4, 5'b00011);
    e[2] = 21'd0;
    e[3] = 21'd0;
    ir    = IR_ADD;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'b0;
      clear = (i == 1);
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL clear_mid[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    clear = 1'b0;
    $display("test_clear_mid: aborted in T4, no done");
  endtask

  task automatic test_back_to_back();
    vec_t e[7];
    e[0] = mk(E_RR_T3, 5'd0);
    e[1] = mk(E_RR_T4, 5'b00011);
    e[2] = mk(E_WB, 5'd0);
    e[3] = 21'd0;
    e[4] = mk(E_RR_T3, 5'd0);
    e[5] = mk(E_IMM_T4, 5'b01101);
    e[6] = mk(E_WB, 5'd0);
    ir    = IR_ADD;
    start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start = 1'b0;
      // next instruction requested during done; it only starts from IDLE
      if (i == 2 || i == 3) begin
        start = 1'b1;
        ir    = IR_ANDI;
      end
      n_checks++;
      if (obs0() !== e[i] || obs1() !== e[i])
        $display("FAIL b2b[%0d] got %h/%h want %h", i, obs0(), obs1(), e[i]);
      else
        n_pass++;
    end
    step();
    $display("test_back_to_back: add then andi with one idle cycle");
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    ir    = 32'd0;
    @(negedge clk);
    test_reset();
    test_add();
    test_addi();
    test_mul();
    test_unary_and_illegal();
    test_start_while_busy();
    test_clear_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
